// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the gameboy CPU: register file layout, bus request encodings and accessors.
// Pure declarations and combinational helpers; no state, no flow control.
package gb_cpu_common_pkg;

    typedef enum logic [3:0] {
        REG_A,
        REG_F,
        REG_B,
        REG_C,
        REG_D,
        REG_E,
        REG_H,
        REG_L,
        REG_SP_H,
        REG_SP_L,
        REG_PC_H,
        REG_PC_L,
        REG_IR,
        REG_TMP_H,
        REG_TMP_L
    } regfile_r8_t;

    typedef enum logic [2:0] {
        REG_AF,
        REG_BC,
        REG_DE,
        REG_HL,
        REG_SP,
        REG_PC,
        REG_TMP
    } regfile_r16_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] f;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] sp_hi;
        logic [7:0] sp_lo;
        logic [7:0] pc_hi;
        logic [7:0] pc_lo;
        logic [7:0] ir;
        logic [7:0] tmp_hi;
        logic [7:0] tmp_lo;
    } regfile_t;

    typedef enum logic [1:0] {
        BUS_NONE,
        BUS_READ,
        BUS_WRITE
    } bus_op_t;

    typedef enum logic [1:0] {
        ADDR_R16,
        ADDR_HIGH_C,
        ADDR_HIGH_TMP
    } addr_mode_t;

    localparam logic [7:0] HIGH_PAGE = 8'hFF;
    localparam logic [7:0] OPEN_BUS  = 8'hFF;

    function automatic logic [7:0] getRegister8(input regfile_t regs, input regfile_r8_t sel);
        logic [7:0] val;
        val = 8'h00;
        case (sel)
            REG_A:     val = regs.a;
            REG_F:     val = regs.f;
            REG_B:     val = regs.b;
            REG_C:     val = regs.c;
            REG_D:     val = regs.d;
            REG_E:     val = regs.e;
            REG_H:     val = regs.h;
            REG_L:     val = regs.l;
            REG_SP_H:  val = regs.sp_hi;
            REG_SP_L:  val = regs.sp_lo;
            REG_PC_H:  val = regs.pc_hi;
            REG_PC_L:  val = regs.pc_lo;
            REG_IR:    val = regs.ir;
            REG_TMP_H: val = regs.tmp_hi;
            REG_TMP_L: val = regs.tmp_lo;
            default:   val = 8'h00;
        endcase
        return val;
    endfunction

    function automatic logic [7:0] getRegisterHigh(input regfile_t regs, input regfile_r16_t sel);
        logic [7:0] val;
        val = 8'h00;
        case (sel)
            REG_AF:  val = regs.a;
            REG_BC:  val = regs.b;
            REG_DE:  val = regs.d;
            REG_HL:  val = regs.h;
            REG_SP:  val = regs.sp_hi;
            REG_PC:  val = regs.pc_hi;
            REG_TMP: val = regs.tmp_hi;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    function automatic logic [7:0] getRegisterLow(input regfile_t regs, input regfile_r16_t sel);
        logic [7:0] val;
        val = 8'h00;
        case (sel)
            REG_AF:  val = regs.f;
            REG_BC:  val = regs.c;
            REG_DE:  val = regs.e;
            REG_HL:  val = regs.l;
            REG_SP:  val = regs.sp_lo;
            REG_PC:  val = regs.pc_lo;
            REG_TMP: val = regs.tmp_lo;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Reads may only land in registers the control unit consumes straight off the bus.
    function automatic logic isBusReadDst(input regfile_r8_t dst);
        return (dst == REG_IR) || (dst == REG_TMP_L) || (dst == REG_TMP_H);
    endfunction

endpackage

// File: rtl/gb_cpu_mem_addr_mux.sv
// Selects the external address and write byte from the live register file contents.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to capture the result.
module gb_cpu_mem_addr_mux
    import gb_cpu_common_pkg::*;
(
    input  regfile_t     registers,
    input  addr_mode_t   addr_mode,
    input  regfile_r16_t addr_src,
    input  regfile_r8_t  wdata_src,
    output logic [15:0]  addr,
    output logic [7:0]   wdata
);

    always_comb begin
        addr = {getRegisterHigh(registers, addr_src), getRegisterLow(registers, addr_src)};
        case (addr_mode)
            ADDR_HIGH_C:   addr = {HIGH_PAGE, registers.c};
            ADDR_HIGH_TMP: addr = {HIGH_PAGE, registers.tmp_lo};
            default:       ;
        endcase
        wdata = getRegister8(registers, wdata_src);
    end

endmodule

// File: rtl/gb_cpu_mem_if.sv
// CPU-side memory bus master: snapshots one request, runs the mem_req/mem_ack handshake, returns read bytes to the regfile.
// Latency: 2 cycles per access at zero wait (ACCESS + RESP), plus one per wait state, aborted after MAX_WAIT waits.
// Backpressure: busy stalls the control unit during ACCESS; a new request may be taken in the RESP cycle.
module gb_cpu_mem_if
    import gb_cpu_common_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  bus_op_t      bus_op,
    input  addr_mode_t   addr_mode,
    input  regfile_r16_t addr_src,
    input  regfile_r8_t  wdata_src,
    input  regfile_r8_t  rdata_dst,
    input  regfile_t     registers,
    output logic         busy,
    output logic         bus_error,
    output logic         mem_req,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_ack,
    output regfile_r8_t  data_bus_req,
    output logic [7:0]   data_bus_data,
    output logic         data_bus_wren
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_nxt;
    regfile_r8_t      dst_q, dst_nxt;

    logic             busy_nxt, bus_error_nxt, mem_req_nxt, mem_we_nxt;
    logic [15:0]      mem_addr_nxt;
    logic [7:0]       mem_wdata_nxt;
    regfile_r8_t      data_bus_req_nxt;
    logic [7:0]       data_bus_data_nxt;
    logic             data_bus_wren_nxt;

    logic [15:0]      sel_addr;
    logic [7:0]       sel_wdata;
    logic             req_vld, req_illegal, can_accept;

    gb_cpu_mem_addr_mux u_addr_mux (
        .registers (registers),
        .addr_mode (addr_mode),
        .addr_src  (addr_src),
        .wdata_src (wdata_src),
        .addr      (sel_addr),
        .wdata     (sel_wdata)
    );

    assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign req_illegal = (bus_op == BUS_READ) && !isBusReadDst(rdata_dst);
    assign req_vld     = ((bus_op == BUS_READ) || (bus_op == BUS_WRITE)) && !req_illegal;

    always_comb begin
        state_nxt         = state_q;
        wait_cnt_nxt      = wait_cnt_q;
        dst_nxt           = dst_q;
        busy_nxt          = busy;
        bus_error_nxt     = 1'b0;
        mem_req_nxt       = mem_req;
        mem_we_nxt        = mem_we;
        mem_addr_nxt      = mem_addr;
        mem_wdata_nxt     = mem_wdata;
        data_bus_req_nxt  = data_bus_req;
        data_bus_data_nxt = data_bus_data;
        data_bus_wren_nxt = 1'b0;

        if (can_accept) begin
            state_nxt   = ST_IDLE;
            mem_req_nxt = 1'b0;
            busy_nxt    = 1'b0;
            if (req_vld) begin
                state_nxt     = ST_ACCESS;
                wait_cnt_nxt  = '0;
                mem_req_nxt   = 1'b1;
                busy_nxt      = 1'b1;
                mem_we_nxt    = (bus_op == BUS_WRITE);
                mem_addr_nxt  = sel_addr;
                mem_wdata_nxt = sel_wdata;
                dst_nxt       = rdata_dst;
            end else if (req_illegal) begin
                bus_error_nxt = 1'b1;
            end
        end else if (state_q == ST_ACCESS) begin
            if (mem_ack) begin
                state_nxt   = ST_RESP;
                mem_req_nxt = 1'b0;
                busy_nxt    = 1'b0;
                if (!mem_we) begin
                    data_bus_wren_nxt = 1'b1;
                    data_bus_data_nxt = mem_rdata;
                    data_bus_req_nxt  = dst_q;
                end
            end else begin
                wait_cnt_nxt = wait_cnt_q + 1'b1;
                // Last permitted wait state: give up and hand back open-bus data for reads.
                if (wait_cnt_q == CNT_LAST) begin
                    state_nxt     = ST_RESP;
                    mem_req_nxt   = 1'b0;
                    busy_nxt      = 1'b0;
                    bus_error_nxt = 1'b1;
                    if (!mem_we) begin
                        data_bus_wren_nxt = 1'b1;
                        data_bus_data_nxt = OPEN_BUS;
                        data_bus_req_nxt  = dst_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            dst_q         <= REG_IR;
            busy          <= 1'b0;
            bus_error     <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 16'h0000;
            mem_wdata     <= 8'h00;
            data_bus_req  <= REG_IR;
            data_bus_data <= 8'h00;
            data_bus_wren <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            wait_cnt_q    <= wait_cnt_nxt;
            dst_q         <= dst_nxt;
            busy          <= busy_nxt;
            bus_error     <= bus_error_nxt;
            mem_req       <= mem_req_nxt;
            mem_we        <= mem_we_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_wdata     <= mem_wdata_nxt;
            data_bus_req  <= data_bus_req_nxt;
            data_bus_data <= data_bus_data_nxt;
            data_bus_wren <= data_bus_wren_nxt;
        end
    end

endmodule

// File: tb/tb_gb_cpu_mem_if.sv
// Directed bench for gb_cpu_mem_if: reads, waited writes, timeout, back-to-back, illegal dst, reset abort.
module tb_gb_cpu_mem_if;
    import gb_cpu_common_pkg::*;

    logic         clk;
    logic         reset;
    bus_op_t      bus_op;
    addr_mode_t   addr_mode;
    regfile_r16_t addr_src;
    regfile_r8_t  wdata_src;
    regfile_r8_t  rdata_dst;
    regfile_t     regs;
    logic         busy;
    logic         bus_error;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         mem_ack;
    regfile_r8_t  data_bus_req;
    logic [7:0]   data_bus_data;
    logic         data_bus_wren;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rf_model [16];

    gb_cpu_mem_if #(.MAX_WAIT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_op        (bus_op),
        .addr_mode     (addr_mode),
        .addr_src      (addr_src),
        .wdata_src     (wdata_src),
        .rdata_dst     (rdata_dst),
        .registers     (regs),
        .busy          (busy),
        .bus_error     (bus_error),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .data_bus_req  (data_bus_req),
        .data_bus_data (data_bus_data),
        .data_bus_wren (data_bus_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile stand-in: captures the returned byte at the negedge of the RESP cycle.
    always @(negedge clk) begin
        if (data_bus_wren)
            rf_model[4'(data_bus_req)] <= data_bus_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus_op    = BUS_NONE;
        addr_mode = ADDR_R16;
        addr_src  = REG_HL;
        wdata_src = REG_A;
        rdata_dst = REG_IR;
        regs      = '0;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        step();
        step();

        chk("rst_mem_req",   16'(mem_req),       16'h0);
        chk("rst_mem_we",    16'(mem_we),        16'h0);
        chk("rst_mem_addr",  mem_addr,           16'h0000);
        chk("rst_mem_wdata", 16'(mem_wdata),     16'h00);
        chk("rst_wren",      16'(data_bus_wren), 16'h0);
        chk("rst_db_data",   16'(data_bus_data), 16'h00);
        chk("rst_db_req",    16'(data_bus_req),  16'(REG_IR));
        chk("rst_busy",      16'(busy),          16'h0);
        chk("rst_bus_error", 16'(bus_error),     16'h0);
        reset = 1'b0;
        step();

        // 1: zero-wait read (HL) into IR
        regs.h    = 8'hC1;
        regs.l    = 8'h23;
        bus_op    = BUS_READ;
        addr_mode = ADDR_R16;
        addr_src  = REG_HL;
        rdata_dst = REG_IR;
        step();
        chk("t1_mem_req",  16'(mem_req), 16'h1);
        chk("t1_mem_addr", mem_addr,     16'hC123);
        chk("t1_mem_we",   16'(mem_we),  16'h0);
        chk("t1_busy",     16'(busy),    16'h1);
        bus_op    = BUS_NONE;
        mem_ack   = 1'b1;
        mem_rdata = 8'h3E;
        step();
        chk("t1_resp_req",  16'(mem_req),       16'h0);
        chk("t1_resp_busy", 16'(busy),          16'h0);
        chk("t1_wren",      16'(data_bus_wren), 16'h1);
        chk("t1_db_req",    16'(data_bus_req),  16'(REG_IR));
        chk("t1_db_data",   16'(data_bus_data), 16'h3E);
        mem_ack = 1'b0;
        step();
        chk("t1_wren_off", 16'(data_bus_wren), 16'h0);
        chk("t1_idle_req", 16'(mem_req),       16'h0);
        chk("t1_rf_ir",    16'(rf_model[4'(REG_IR)]), 16'h3E);

        // 2: write A to FF00+C with three wait states; A changes after acceptance
        regs.a    = 8'h5A;
        regs.c    = 8'h44;
        bus_op    = BUS_WRITE;
        addr_mode = ADDR_HIGH_C;
        wdata_src = REG_A;
        step();
        bus_op = BUS_NONE;
        regs.a = 8'h00;
        regs.c = 8'h99;
        for (int i = 0; i < 4; i++) begin
            chk("t2_mem_req",   16'(mem_req),       16'h1);
            chk("t2_mem_we",    16'(mem_we),        16'h1);
            chk("t2_mem_addr",  mem_addr,           16'hFF44);
            chk("t2_mem_wdata", 16'(mem_wdata),     16'h5A);
            chk("t2_busy",      16'(busy),          16'h1);
            chk("t2_no_wren",   16'(data_bus_wren), 16'h0);
            if (i == 3) mem_ack = 1'b1;
            step();
        end
        chk("t2_resp_req",  16'(mem_req),       16'h0);
        chk("t2_resp_busy", 16'(busy),          16'h0);
        chk("t2_resp_wren", 16'(data_bus_wren), 16'h0);
        chk("t2_resp_err",  16'(bus_error),     16'h0);
        mem_ack = 1'b0;
        step();

        // 3: timeout on a read to FF00+TMP_L into TMP_L
        regs.tmp_lo = 8'h80;
        bus_op      = BUS_READ;
        addr_mode   = ADDR_HIGH_TMP;
        rdata_dst   = REG_TMP_L;
        step();
        bus_op = BUS_NONE;
        chk("t3_mem_addr", mem_addr, 16'hFF80);
        for (int i = 0; i < 8; i++) begin
            chk("t3_mem_req", 16'(mem_req),       16'h1);
            chk("t3_no_err",  16'(bus_error),     16'h0);
            chk("t3_no_wren", 16'(data_bus_wren), 16'h0);
            step();
        end
        chk("t3_req_drop", 16'(mem_req),       16'h0);
        chk("t3_err",      16'(bus_error),     16'h1);
        chk("t3_wren",     16'(data_bus_wren), 16'h1);
        chk("t3_db_data",  16'(data_bus_data), 16'hFF);
        chk("t3_db_req",   16'(data_bus_req),  16'(REG_TMP_L));
        chk("t3_busy",     16'(busy),          16'h0);
        step();
        chk("t3_err_off",  16'(bus_error),     16'h0);
        chk("t3_wren_off", 16'(data_bus_wren), 16'h0);
        chk("t3_rf_tmpl",  16'(rf_model[4'(REG_TMP_L)]), 16'hFF);

        // 4: back-to-back zero-wait reads, second presented during RESP
        regs.b    = 8'h12;
        regs.c    = 8'h44;
        regs.d    = 8'h34;
        regs.e    = 8'h56;
        bus_op    = BUS_READ;
        addr_mode = ADDR_R16;
        addr_src  = REG_BC;
        rdata_dst = REG_TMP_L;
        step();
        chk("t4_req_a",  16'(mem_req), 16'h1);
        chk("t4_addr_a", mem_addr,     16'h1244);
        bus_op    = BUS_NONE;
        mem_ack   = 1'b1;
        mem_rdata = 8'hA1;
        step();
        chk("t4_gap",     16'(mem_req),       16'h0);
        chk("t4_wren_a",  16'(data_bus_wren), 16'h1);
        chk("t4_dst_a",   16'(data_bus_req),  16'(REG_TMP_L));
        chk("t4_data_a",  16'(data_bus_data), 16'hA1);
        bus_op    = BUS_READ;
        addr_src  = REG_DE;
        rdata_dst = REG_TMP_H;
        mem_rdata = 8'hB2;
        step();
        chk("t4_req_b",   16'(mem_req),       16'h1);
        chk("t4_addr_b",  mem_addr,           16'h3456);
        chk("t4_wren_mid", 16'(data_bus_wren), 16'h0);
        chk("t4_busy_b",  16'(busy),          16'h1);
        bus_op = BUS_NONE;
        step();
        chk("t4_req_b_off", 16'(mem_req),       16'h0);
        chk("t4_wren_b",    16'(data_bus_wren), 16'h1);
        chk("t4_dst_b",     16'(data_bus_req),  16'(REG_TMP_H));
        chk("t4_data_b",    16'(data_bus_data), 16'hB2);
        mem_ack = 1'b0;
        step();
        chk("t4_idle_wren", 16'(data_bus_wren), 16'h0);
        chk("t4_idle_req",  16'(mem_req),       16'h0);

        // 5: read into B is illegal
        bus_op    = BUS_READ;
        rdata_dst = REG_B;
        step();
        chk("t5_no_req", 16'(mem_req),   16'h0);
        chk("t5_err",    16'(bus_error), 16'h1);
        chk("t5_busy",   16'(busy),      16'h0);
        bus_op    = BUS_NONE;
        rdata_dst = REG_IR;
        step();
        chk("t5_err_off", 16'(bus_error), 16'h0);
        chk("t5_idle",    16'(mem_req),   16'h0);

        // 6: reset during the second wait cycle, ack arrives after reset
        bus_op    = BUS_READ;
        addr_src  = REG_HL;
        rdata_dst = REG_TMP_H;
        step();
        bus_op = BUS_NONE;
        chk("t6_req_on", 16'(mem_req), 16'h1);
        step();
        chk("t6_waiting", 16'(mem_req), 16'h1);
        reset = 1'b1;
        step();
        chk("t6_rst_req",  16'(mem_req),       16'h0);
        chk("t6_rst_busy", 16'(busy),          16'h0);
        chk("t6_rst_wren", 16'(data_bus_wren), 16'h0);
        chk("t6_rst_dst",  16'(data_bus_req),  16'(REG_IR));
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        step();
        chk("t6_late_req",  16'(mem_req),       16'h0);
        chk("t6_late_wren", 16'(data_bus_wren), 16'h0);
        chk("t6_late_busy", 16'(busy),          16'h0);
        mem_ack = 1'b0;
        step();
        chk("t6_after_wren", 16'(data_bus_wren), 16'h0);
        chk("t6_after_err",  16'(bus_error),     16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_cpu_mem_if.md
Name: gb_cpu_mem_if

Overview:
Memory bus interface for the gameboy CPU. It is the reader/driver end of the regfile's data-bus write port.
- Takes one byte-wide bus request per M-cycle from the control unit.
- Resolves the address and write data from the current register file contents.
- Runs the external memory handshake, including wait states and timeout.
- For reads, returns the fetched byte to the regfile through the data_bus_req / data_bus_data / data_bus_wren port.
- Sits between the control unit, the regfile and the system memory map.

Parameters:
MAX_WAIT, 8, maximum cycles in ACCESS without mem_ack before the access is aborted; legal range 1..255.

Ports:
clk  input  1  machine clock
reset  input  1  synchronous, active-high
bus_op  input  bus_op_t(2)  BUS_NONE / BUS_READ / BUS_WRITE request from control unit
addr_mode  input  addr_mode_t(2)  ADDR_R16 / ADDR_HIGH_C / ADDR_HIGH_TMP
addr_src  input  regfile_r16_t  register pair used as the address in ADDR_R16 mode
wdata_src  input  regfile_r8_t  8-bit register driven out on a write
rdata_dst  input  regfile_r8_t  destination of a read; only REG_IR, REG_TMP_L and REG_TMP_H are legal
registers  input  regfile_t  current regfile contents
busy  output  1  access in flight; control unit stalls while this is high
bus_error  output  1  one-cycle pulse on timeout or illegal request
mem_req  output  1  external access strobe
mem_we  output  1  1 = write, 0 = read
mem_addr  output  16  external address
mem_wdata  output  8  external write data
mem_rdata  input  8  external read data
mem_ack  input  1  access complete; sampled at posedge
data_bus_req  output  regfile_r8_t  regfile target
data_bus_data  output  8  byte to the regfile
data_bus_wren  output  1  regfile write enable

Behaviour:
- Reset: state=IDLE. Outputs clear to: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_bus_wren=0, data_bus_data=0, data_bus_req=REG_IR, busy=0, bus_error=0, wait counter=0.
- Reset during any state aborts the access: mem_req falls at that same edge and no wren is issued.
- State IDLE:
  - A request is accepted at a posedge when bus_op!=BUS_NONE.
  - At acceptance, the following are snapshotted into holding registers: address, write data, direction and rdata_dst.
  - Inputs that change later are ignored until the next acceptance.
- Address resolution, computed at acceptance:
  - ADDR_R16 → {hi, lo} of addr_src, using getRegisterHigh / getRegisterLow.
  - ADDR_HIGH_C → {8'hFF, registers.c}.
  - ADDR_HIGH_TMP → {8'hFF, registers.tmp_lo}.
- Write data = the value of wdata_src at acceptance.
- Illegal request: BUS_READ with rdata_dst outside {IR, TMP_L, TMP_H}. It is not accepted and no bus cycle starts. bus_error pulses for the following cycle and the state stays IDLE.
- State ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata are held constant; busy=1.
  - Each posedge without mem_ack increments the wait counter.
  - mem_ack=1 at a posedge → RESP. For a read, mem_rdata is latched into data_bus_data and rdata_dst into data_bus_req.
  - If the counter reaches MAX_WAIT with no ack → RESP with abort. mem_req drops. A read returns 8'hFF (open bus) and bus_error=1 for one cycle.
- State RESP (exactly one cycle):
  - mem_req=0 and busy=0.
  - data_bus_wren=1 only for reads (completed or aborted). The regfile captures the byte at this cycle's negedge.
  - Writes produce no wren.
  - A new request can be accepted at the posedge that ends RESP; it goes straight to ACCESS with no IDLE bubble. Otherwise the next state is IDLE.
- Latency:
  - Accept at edge e0 → mem_req high from e0 → ack sampled at e1 (zero wait) → RESP cycle e1..e2.
  - Minimum of 2 cycles per access; each wait state adds one.
- mem_ack outside ACCESS is ignored.
- bus_error is never held longer than one cycle.
- Wait counter width is $clog2(MAX_WAIT+1). It clears on acceptance and never wraps.

Decomposition:
- gb_cpu_common_pkg gains:
  - bus_op_t {BUS_NONE, BUS_READ, BUS_WRITE}
  - addr_mode_t {ADDR_R16, ADDR_HIGH_C, ADDR_HIGH_TMP}
  - localparam HIGH_PAGE = 8'hFF
  - function isBusReadDst(regfile_r8_t)
- Sub-module gb_cpu_mem_addr_mux: combinational address and write-data selection from registers/addr_mode/addr_src/wdata_src.
- The FSM, counter and holding registers stay in gb_cpu_mem_if.

Test Plan:
1. Zero-wait read: HL=16'hC123, ADDR_R16/REG_HL, BUS_READ → REG_IR, mem_ack in the first ACCESS cycle with mem_rdata=8'h3E → mem_addr=C123 and mem_we=0 for 1 cycle; next cycle data_bus_wren=1, data_bus_req=REG_IR, data_bus_data=3E; regfile IR=3E.
2. Wait-state write: A=8'h5A, C=8'h44, ADDR_HIGH_C, BUS_WRITE wdata_src=REG_A, ack after 3 wait cycles → mem_addr=FF44, mem_wdata=5A, mem_we=1 held 4 cycles; busy=1 for 4 cycles; no data_bus_wren.
3. Timeout: MAX_WAIT=8, read into TMP_L, ack never asserted → mem_req high for 8 cycles, then bus_error=1 for 1 cycle, data_bus_wren=1 with data 8'hFF to REG_TMP_L.
4. Back-to-back: two reads (TMP_L, then TMP_H), the second presented during RESP, both zero-wait → mem_req shows one 1-cycle gap; two wren pulses 2 cycles apart with the correct dst each.
5. Illegal destination: BUS_READ with rdata_dst=REG_B → mem_req stays 0, bus_error pulses once, state stays IDLE.
6. Reset mid-access: reset asserted during the 2nd wait cycle, with ack arriving the next cycle → mem_req=0 after the reset edge, the late ack is ignored, no wren, busy=0.
